memory_pairs_judge: RTL and testbench

//  Player-side consumer of the dealt deck. It latches the six 4-bit card values and the deal-complete flag from the

---
 rtl/memory_pairs_judge_if.sv | 9 +
 rtl/memory_pairs_judge.sv | 192 +++++++++++++++++++
 tb/tb_memory_pairs_judge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/memory_pairs_judge_if.sv
// Pick handshake between the player input logic and the judge.
interface memory_pairs_judge_if;
  logic       sel_valid;
  logic [2:0] sel_idx;
  logic       sel_ready;

  modport master (output sel_valid, output sel_idx, input sel_ready);
  modport slave  (input sel_valid, input sel_idx, output sel_ready);
endinterface

// File: rtl/memory_pairs_judge.sv
// Memory-pairs judge: latches the dealt deck, validates and compares player picks,
// tracks matches and misses, and flags win or loss. All outputs are registered.
module memory_pairs_judge #(
  parameter int VAL_W         = 4,
  parameter int REVEAL_CYCLES = 8,
  parameter int MAX_TRIES     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deal_done,
  input  logic [VAL_W-1:0]     card_a,
  input  logic [VAL_W-1:0]     card_b,
  input  logic [VAL_W-1:0]     card_c,
  input  logic [VAL_W-1:0]     card_d,
  input  logic [VAL_W-1:0]     card_e,
  input  logic [VAL_W-1:0]     card_f,
  input  logic                 new_game,
  memory_pairs_judge_if.slave  pick,
  output logic [5:0]           show_mask,
  output logic [5:0]           match_mask,
  output logic                 match_pls,
  output logic                 miss_pls,
  output logic                 rej_pls,
  output logic [3:0]           tries,
  output logic                 game_won,
  output logic                 game_lost
);

  localparam int CNT_W = $clog2(REVEAL_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, PICK1, PICK2, CMP, SHOW, WIN, LOSE
  } state_e;

  state_e               state_q, state_d;
  logic [VAL_W-1:0]     deck_q [6];
  logic [VAL_W-1:0]     deck_d [6];
  logic [2:0]           idx1_q, idx1_d, idx2_q, idx2_d;
  logic [5:0]           match_q, match_d, show_q, show_d;
  logic [3:0]           tries_q, tries_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 match_pls_q, match_pls_d, miss_pls_q, miss_pls_d;
  logic                 rej_pls_q, rej_pls_d, won_q, won_d, lost_q, lost_d;
  logic                 sel_ready_q, sel_ready_d;

  function automatic logic [5:0] onehot(input logic [2:0] idx);
    return (idx <= 3'd5) ? (6'b000001 << idx) : 6'b000000;
  endfunction

  logic       accept, legal, pair_eq, all_matched;
  logic [5:0] sel_bit, pair_bits;

  assign accept      = pick.sel_valid && sel_ready_q;
  assign sel_bit     = onehot(pick.sel_idx);
  // Out-of-range picks yield an empty one-hot, so the first term catches them.
  assign legal       = (sel_bit != 6'b0) && ((match_q & sel_bit) == 6'b0) &&
                       !(state_q == PICK2 && pick.sel_idx == idx1_q);
  assign pair_bits   = onehot(idx1_q) | onehot(idx2_q);
  assign pair_eq     = (deck_q[idx1_q] == deck_q[idx2_q]);
  assign all_matched = ((match_q | pair_bits) == 6'h3F);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, otherwise untaken branches infer latches.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (deal_done) state_d = LOAD;
        LOAD:    state_d = PICK1;
        PICK1:   if (accept && legal) state_d = PICK2;
        PICK2:   if (accept && legal) state_d = CMP;
        CMP:     state_d = pair_eq ? (all_matched ? WIN : PICK1) : SHOW;
        SHOW:    if (cnt_q == '0) state_d = (tries_q == 4'(MAX_TRIES)) ? LOSE : PICK1;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    deck_d      = deck_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    match_d     = match_q;
    show_d      = show_q;
    tries_d     = tries_q;
    cnt_d       = cnt_q;
    match_pls_d = 1'b0;
    miss_pls_d  = 1'b0;
    rej_pls_d   = 1'b0;
    won_d       = won_q;
    lost_d      = lost_q;
    if (new_game) begin
      match_d = '0;
      show_d  = '0;
      tries_d = '0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          deck_d  = '{card_a, card_b, card_c, card_d, card_e, card_f};
          match_d = '0;
          show_d  = '0;
          tries_d = '0;
        end
        PICK1, PICK2: begin
          if (accept) begin
            if (!legal) begin
              rej_pls_d = 1'b1;
            end else begin
              show_d = show_q | sel_bit;
              if (state_q == PICK1) idx1_d = pick.sel_idx;
              else                  idx2_d = pick.sel_idx;
            end
          end
        end
        CMP: begin
          if (pair_eq) begin
            match_d     = match_q | pair_bits;
            match_pls_d = 1'b1;
            won_d       = all_matched;
          end else begin
            miss_pls_d = 1'b1;
            tries_d    = (tries_q == 4'(MAX_TRIES)) ? tries_q : tries_q + 4'd1;
            cnt_d      = CNT_W'(REVEAL_CYCLES);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            show_d = match_q;
            lost_d = (tries_q == 4'(MAX_TRIES));
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    sel_ready_d = (state_d == PICK1) || (state_d == PICK2);
  end

  // NOTE: the deck is six small registers, so it is reset like any other flop rather than left as RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) deck_q[i] <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      match_q     <= '0;
      show_q      <= '0;
      tries_q     <= '0;
      cnt_q       <= '0;
      match_pls_q <= 1'b0;
      miss_pls_q  <= 1'b0;
      rej_pls_q   <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      sel_ready_q <= 1'b0;
    end else begin
      deck_q      <= deck_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      match_q     <= match_d;
      show_q      <= show_d;
      tries_q     <= tries_d;
      cnt_q       <= cnt_d;
      match_pls_q <= match_pls_d;
      miss_pls_q  <= miss_pls_d;
      rej_pls_q   <= rej_pls_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      sel_ready_q <= sel_ready_d;
    end
  end

  assign pick.sel_ready = sel_ready_q;
  assign show_mask      = show_q;
  assign match_mask     = match_q;
  assign match_pls      = match_pls_q;
  assign miss_pls       = miss_pls_q;
  assign rej_pls        = rej_pls_q;
  assign tries          = tries_q;
  assign game_won       = won_q;
  assign game_lost      = lost_q;

endmodule

// File: tb/tb_memory_pairs_judge.sv
// Directed bench for memory_pairs_judge: one game won, one game lost, and a reset mid-reveal.
module tb_memory_pairs_judge;
  localparam int VAL_W = 4;
  localparam int REV   = 8;
  localparam int MAXT  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             deal_done = 1'b0;
  logic             new_game  = 1'b0;
  logic [VAL_W-1:0] ca = '0, cb = '0, cc = '0, cd = '0, ce = '0, cf = '0;
  logic [5:0]       show_mask, match_mask;
  logic             match_pls, miss_pls, rej_pls, game_won, game_lost;
  logic [3:0]       tries;

  memory_pairs_judge_if pif ();

  memory_pairs_judge #(.VAL_W(VAL_W), .REVEAL_CYCLES(REV), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst), .deal_done(deal_done),
    .card_a(ca), .card_b(cb), .card_c(cc), .card_d(cd), .card_e(ce), .card_f(cf),
    .new_game(new_game), .pick(pif.slave),
    .show_mask(show_mask), .match_mask(match_mask),
    .match_pls(match_pls), .miss_pls(miss_pls), .rej_pls(rej_pls),
    .tries(tries), .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pick(input logic [2:0] idx);
    pif.sel_valid = 1'b1;
    pif.sel_idx   = idx;
    tick();
    pif.sel_valid = 1'b0;
  endtask

  task automatic set_deck();
    ca = 4'd1; cb = 4'd2; cc = 4'd3; cd = 4'd1; ce = 4'd2; cf = 4'd3;
  endtask

  initial begin
    pif.sel_valid = 1'b0;
    pif.sel_idx   = '0;
    #12;
    check("rst_show",  32'(show_mask),  32'h0);
    check("rst_match", 32'(match_mask), 32'h0);
    check("rst_ready", 32'(pif.sel_ready), 32'h0);
    check("rst_tries", 32'(tries), 32'h0);

    // Game 1: deal, then scramble the deck inputs to prove the latch holds.
    set_deck();
    deal_done = 1'b1;
    rst = 1'b1;
    tick();
    check("load_ready", 32'(pif.sel_ready), 32'h0);
    tick();
    check("pick1_ready", 32'(pif.sel_ready), 32'h1);
    check("pick1_tries", 32'(tries), 32'h0);
    check("pick1_masks", 32'({show_mask, match_mask}), 32'h0);
    deal_done = 1'b0;
    ca = 4'd9; cb = 4'd8; cc = 4'd7; cd = 4'd6; ce = 4'd5; cf = 4'd4;

    // Match 0-3
    do_pick(3'd0);
    check("p0_show", 32'(show_mask), 32'h01);
    do_pick(3'd3);
    check("p3_show",   32'(show_mask), 32'h09);
    check("cmp_ready", 32'(pif.sel_ready), 32'h0);
    check("cmp_pls",   32'(match_pls), 32'h0);
    tick();
    check("m03_pls",   32'(match_pls), 32'h1);
    check("m03_mask",  32'(match_mask), 32'h09);
    check("m03_ready", 32'(pif.sel_ready), 32'h1);
    tick();
    check("m03_pls_end", 32'(match_pls), 32'h0);

    // Miss 1-2, with a pick attempt during the reveal that must be ignored
    do_pick(3'd1);
    do_pick(3'd2);
    check("miss_show_n", 32'(show_mask), 32'h0F);
    tick();
    check("miss_pls",   32'(miss_pls), 32'h1);
    check("miss_tries", 32'(tries), 32'h1);
    do_pick(3'd5);
    check("show_ign_mask", 32'(show_mask), 32'h0F);
    check("show_ign_rej",  32'(rej_pls), 32'h0);
    check("miss_pls_end",  32'(miss_pls), 32'h0);
    for (int i = 0; i < REV - 1; i++) tick();
    check("reveal_last", 32'(show_mask), 32'h0F);
    tick();
    check("reveal_hide",  32'(show_mask), 32'h09);
    check("reveal_ready", 32'(pif.sel_ready), 32'h1);

    // Illegal picks
    do_pick(3'd0);
    check("rej_matched",      32'(rej_pls), 32'h1);
    check("rej_matched_show", 32'(show_mask), 32'h09);
    do_pick(3'd6);
    check("rej_range", 32'(rej_pls), 32'h1);
    do_pick(3'd4);
    check("p4_rej",  32'(rej_pls), 32'h0);
    check("p4_show", 32'(show_mask), 32'h19);
    do_pick(3'd4);
    check("rej_same",       32'(rej_pls), 32'h1);
    check("rej_same_ready", 32'(pif.sel_ready), 32'h1);
    check("rej_same_show",  32'(show_mask), 32'h19);

    // Finish pairs 1-4 and 2-5
    do_pick(3'd1);
    tick();
    check("m14_mask", 32'(match_mask), 32'h1B);
    check("m14_pls",  32'(match_pls), 32'h1);
    do_pick(3'd2);
    do_pick(3'd5);
    tick();
    check("won",       32'(game_won), 32'h1);
    check("won_mask",  32'(match_mask), 32'h3F);
    check("won_show",  32'(show_mask), 32'h3F);
    check("won_ready", 32'(pif.sel_ready), 32'h0);
    do_pick(3'd0);
    check("won_hold", 32'(game_won), 32'h1);
    check("won_rej",  32'(rej_pls), 32'h0);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_won",   32'(game_won), 32'h0);
    check("ng_masks", 32'({show_mask, match_mask}), 32'h0);
    check("ng_tries", 32'(tries), 32'h0);
    tick();
    check("ng_idle_ready", 32'(pif.sel_ready), 32'h0);

    // Game 2: two misses lose the game
    set_deck();
    deal_done = 1'b1;
    tick();
    tick();
    check("g2_ready", 32'(pif.sel_ready), 32'h1);
    do_pick(3'd0);
    do_pick(3'd1);
    tick();
    check("g2_t1", 32'(tries), 32'h1);
    for (int i = 0; i < REV + 1; i++) tick();
    check("g2_back", 32'(pif.sel_ready), 32'h1);
    do_pick(3'd0);
    do_pick(3'd2);
    tick();
    check("g2_t2",   32'(tries), 32'h2);
    check("g2_miss", 32'(miss_pls), 32'h1);
    for (int i = 0; i < REV; i++) tick();
    check("g2_not_lost_yet", 32'(game_lost), 32'h0);
    tick();
    check("lost",       32'(game_lost), 32'h1);
    check("lost_ready", 32'(pif.sel_ready), 32'h0);
    check("lost_show",  32'(show_mask), 32'h0);
    tick();
    check("lost_hold", 32'(game_lost), 32'h1);

    // Game 3: async reset in the middle of a reveal
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_lost", 32'(game_lost), 32'h0);
    tick();
    tick();
    do_pick(3'd0);
    do_pick(3'd1);
    tick();
    tick();
    check("g3_show", 32'(show_mask), 32'h03);
    #2;
    rst = 1'b0;
    #1;
    check("arst_show",  32'(show_mask), 32'h0);
    check("arst_tries", 32'(tries), 32'h0);
    check("arst_pls",   32'({match_pls, miss_pls, rej_pls, game_won, game_lost}), 32'h0);
    check("arst_ready", 32'(pif.sel_ready), 32'h0);
    tick();
    check("arst_held", 32'(pif.sel_ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
